// File: rtl/pwm_breathe_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_breathe_ctrl
// Multi-channel LED PWM controller with a shared clock prescaler and PWM
// counter. Each channel has a shadow duty/mode pair that is written at any
// time and copied to the active pair only when the PWM counter wraps, so a
// period in progress is never disturbed. Channels in breathe mode ramp their
// brightness up and down by one step per period, between 0 and the
// programmed ceiling.
// ---------------------------------------------------------------------------
module pwm_breathe_ctrl #(
    parameter int  N_CH    = 4,
    parameter int  CNT_W   = 8,
    parameter int  CLK_DIV = 256,
    localparam int AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [CNT_W-1:0] wr_duty_i,
    input  logic             wr_mode_i,
    output logic [N_CH-1:0]  led_o,
    output logic             period_end_o
);

    // Prescaler width; a divide-by-one prescaler keeps a single constant bit.
    localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = {CNT_W{1'b1}};

    // Breathe ramp direction per channel.
    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_e;

    // Shared timebase.
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_s;
    logic             wrap_s;
    logic             period_end_q;

    // Per-channel programming and ramp state.
    logic [N_CH-1:0]  wr_hit_s;
    logic [CNT_W-1:0] shadow_duty_q [N_CH];
    logic [N_CH-1:0]  shadow_mode_q;
    logic [CNT_W-1:0] next_duty_s   [N_CH];
    logic [N_CH-1:0]  next_mode_s;
    logic [CNT_W-1:0] duty_q        [N_CH];
    logic [N_CH-1:0]  mode_q;
    logic [CNT_W-1:0] level_q       [N_CH];
    dir_e             dir_q         [N_CH];
    logic [N_CH-1:0]  up_hit_s;
    logic [CNT_W-1:0] eff_duty_s    [N_CH];
    logic [N_CH-1:0]  led_d;
    logic [N_CH-1:0]  led_q;

    // Prescaler next state, tick generation and PWM counter wrap detection.
    always_comb begin
        tick_s  = 1'b0;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            if (presc_q == PRESC_LAST) begin
                tick_s  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
        if (tick_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        wrap_s = tick_s && (cnt_q == CNT_LAST);
    end

    // Write decode, wrap-cycle bypass of the shadow, ramp step test and LED compare.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // Out-of-range addresses match no channel, so such writes vanish.
            wr_hit_s[i] = wr_en_i && (wr_addr_i == AW'(i));
            if (wr_hit_s[i]) begin
                next_duty_s[i] = wr_duty_i;
                next_mode_s[i] = wr_mode_i;
            end else begin
                next_duty_s[i] = shadow_duty_q[i];
                next_mode_s[i] = shadow_mode_q[i];
            end
            // One extra bit so level + 1 cannot wrap past the ceiling.
            up_hit_s[i] = (({1'b0, level_q[i]} + (CNT_W + 1)'(1)) >= {1'b0, next_duty_s[i]});
            if (mode_q[i]) begin
                eff_duty_s[i] = level_q[i];
            end else begin
                eff_duty_s[i] = duty_q[i];
            end
            led_d[i] = en_i && (cnt_q < eff_duty_s[i]);
        end
    end

    // Prescaler, PWM counter and the registered one-cycle period-end pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            period_end_q <= wrap_s;
        end
    end

    // Shadow registers accept writes in any cycle, whether or not EN is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_duty_q[i] <= '0;
            end
            shadow_mode_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_hit_s[i]) begin
                    shadow_duty_q[i] <= wr_duty_i;
                    shadow_mode_q[i] <= wr_mode_i;
                end
            end
        end
    end

    // Active duty/mode reload at each wrap, taking a coincident write directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i] <= '0;
            end
            mode_q <= '0;
        end else begin
            if (wrap_s) begin
                for (int i = 0; i < N_CH; i++) begin
                    duty_q[i] <= next_duty_s[i];
                end
                mode_q <= next_mode_s;
            end
        end
    end

    // Breathe ramp FSM: one step per wrap against the ceiling loaded at that wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                level_q[i] <= '0;
                dir_q[i]   <= ST_UP;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wrap_s) begin
                    // A mode change, static mode, or a zero ceiling parks the ramp at 0/UP.
                    if ((next_mode_s[i] != mode_q[i]) || !next_mode_s[i] ||
                        (next_duty_s[i] == '0)) begin
                        level_q[i] <= '0;
                        dir_q[i]   <= ST_UP;
                    end else begin
                        case (dir_q[i])
                            ST_UP: begin
                                // Reaching the ceiling, or a ceiling lowered under the
                                // current level, lands exactly on the ceiling.
                                if (up_hit_s[i]) begin
                                    level_q[i] <= next_duty_s[i];
                                    dir_q[i]   <= ST_DOWN;
                                end else begin
                                    level_q[i] <= level_q[i] + CNT_W'(1);
                                end
                            end
                            ST_DOWN: begin
                                if (level_q[i] == '0) begin
                                    level_q[i] <= CNT_W'(1);
                                    dir_q[i]   <= ST_UP;
                                end else begin
                                    level_q[i] <= level_q[i] - CNT_W'(1);
                                end
                            end
                            default: begin
                                level_q[i] <= '0;
                                dir_q[i]   <= ST_UP;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // LED output register; EN low forces every channel off on the next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o        = led_q;
    assign period_end_o = period_end_q;

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pwm_breathe_ctrl. A behavioural model (plain integers, one
// step per clock) predicts LED and PERIOD_END every cycle; directed periods
// are additionally measured as high-time per period and compared with
// hand-computed values. Five channels are used so that write addresses
// 5..7 exist on the 3-bit address port and must be ignored.
// ---------------------------------------------------------------------------
module tb_pwm_breathe_ctrl;

    localparam int N_CH    = 5;
    localparam int CNT_W   = 4;
    localparam int CLK_DIV = 2;
    localparam int AW      = 3;
    localparam int TOP     = 1 << CNT_W;
    localparam int BREATHE_HI [8] = '{0, 2, 4, 6, 4, 2, 0, 2};

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             en      = 1'b1;
    logic             wr_en   = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [CNT_W-1:0] wr_duty = '0;
    logic             wr_mode = 1'b0;
    logic [N_CH-1:0]  led;
    logic             pe;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int              m_presc;
    int              m_cnt;
    int              m_sd [N_CH];
    int              m_sm [N_CH];
    int              m_ad [N_CH];
    int              m_am [N_CH];
    int              m_lvl [N_CH];
    int              m_up [N_CH];
    logic [N_CH-1:0] m_led;
    logic            m_pe;

    // Directed-measurement schedule and results.
    int s_at [8];
    int s_ch [8];
    int s_du [8];
    int s_mo [8];
    int s_n     = 0;
    int en_from = -1;
    int en_len  = 0;
    int hi [16][N_CH];
    int plen [16];

    pwm_breathe_ctrl #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_duty_i    (wr_duty),
        .wr_mode_i    (wr_mode),
        .led_o        (led),
        .period_end_o (pe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_cnt   = 0;
        m_led   = '0;
        m_pe    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_sd[i] = 0; m_sm[i] = 0; m_ad[i] = 0; m_am[i] = 0;
            m_lvl[i] = 0; m_up[i] = 1;
        end
    endtask

    // One clock of the controller, straight from the rules: brightness from
    // the state at the start of the cycle, then timebase, writes, wrap.
    task automatic model_step();
        logic [N_CH-1:0] nl;
        bit tick, wrap;
        int eff, c, nm, a;
        for (int i = 0; i < N_CH; i++) begin
            eff   = (m_am[i] != 0) ? m_lvl[i] : m_ad[i];
            nl[i] = en && (m_cnt < eff);
        end
        tick = en && (m_presc == CLK_DIV - 1);
        wrap = tick && (m_cnt == TOP - 1);
        if (en) m_presc = (m_presc + 1) % CLK_DIV;
        if (tick) m_cnt = (m_cnt + 1) % TOP;
        a = int'(wr_addr);
        if (wr_en && a < N_CH) begin
            m_sd[a] = int'(wr_duty);
            m_sm[a] = int'(wr_mode);
        end
        if (wrap) begin
            for (int i = 0; i < N_CH; i++) begin
                c  = m_sd[i];
                nm = m_sm[i];
                if (nm != m_am[i] || nm == 0 || c == 0) begin
                    m_lvl[i] = 0; m_up[i] = 1;
                end else if (m_up[i] != 0) begin
                    if (m_lvl[i] + 1 >= c) begin m_lvl[i] = c; m_up[i] = 0; end
                    else m_lvl[i] = m_lvl[i] + 1;
                end else begin
                    if (m_lvl[i] == 0) begin m_lvl[i] = 1; m_up[i] = 1; end
                    else m_lvl[i] = m_lvl[i] - 1;
                end
                m_ad[i] = c;
                m_am[i] = nm;
            end
        end
        m_led = nl;
        m_pe  = wrap;
    endtask

    // Model clocking: asynchronous reset, otherwise one step per rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("led_vs_model", int'(led), int'(m_led));
                chk("period_end_vs_model", int'(pe), int'(m_pe));
            end
        end
    end

    task automatic add_wr(input int g, input int ch, input int du, input int mo);
        s_at[s_n] = g; s_ch[s_n] = ch; s_du[s_n] = du; s_mo[s_n] = mo;
        s_n++;
    endtask

    task automatic wait_pe();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (pe) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_pe: no PERIOD_END within 200 cycles (t=%0t)", $time);
        end
    endtask

    // Measure np consecutive periods (LED high cycles per channel and length),
    // applying scheduled writes / EN drop indexed by sample number g.
    task automatic run_periods(input int np);
        int g;
        bit seen;
        wait_pe();
        g = 0;
        for (int p = 0; p < np; p++) begin
            for (int c = 0; c < N_CH; c++) hi[p][c] = 0;
            plen[p] = 0;
            seen    = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                plen[p]++;
                for (int c = 0; c < N_CH; c++) hi[p][c] += int'(led[c]);
                if (pe) seen = 1'b1;
                wr_en = 1'b0;
                en    = !(en_from >= 0 && g >= en_from && g < en_from + en_len);
                for (int j = 0; j < s_n; j++) begin
                    if (s_at[j] == g) begin
                        wr_en   = 1'b1;
                        wr_addr = AW'(s_ch[j]);
                        wr_duty = CNT_W'(s_du[j]);
                        wr_mode = s_mo[j][0];
                    end
                end
                g++;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL period_timeout: period %0d did not end (t=%0t)", p, $time);
            end
        end
        s_n     = 0;
        en_from = -1;
        en_len  = 0;
        wr_en   = 1'b0;
        en      = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 0);
        chk("reset_pe", int'(pe), 0);
        rst = 1'b0;

        // Static duty; a mid-period write only shows from the next period.
        add_wr(3, 0, 5, 0);
        add_wr(5, 1, 12, 0);
        add_wr(74, 0, 12, 0);
        run_periods(4);
        chk("t1_p1_ch0_hi", hi[1][0], 10);
        chk("t1_p2_ch0_hi_midwrite", hi[2][0], 10);
        chk("t1_p3_ch0_hi", hi[3][0], 24);
        chk("t1_p1_ch1_hi", hi[1][1], 24);
        chk("t1_p1_len", plen[1], 32);
        chk("t1_p2_len", plen[2], 32);

        // Duty extremes and out-of-range addresses.
        add_wr(3, 0, 15, 0);
        add_wr(4, 1, 0, 0);
        add_wr(5, 5, 9, 0);
        add_wr(6, 7, 9, 1);
        run_periods(3);
        chk("t2_ch0_max_p1", hi[1][0], 30);
        chk("t2_ch0_max_p2", hi[2][0], 30);
        chk("t2_ch1_zero_p1", hi[1][1], 0);
        chk("t2_ch1_zero_p2", hi[2][1], 0);
        chk("t2_ch3_untouched", hi[2][3], 0);
        chk("t2_ch4_untouched", hi[2][4], 0);

        // Breathe with ceiling 3, then ceiling 0.
        add_wr(10, 1, 3, 1);
        run_periods(9);
        for (int p = 1; p < 9; p++) chk("t3_breathe_hi", hi[p][1], BREATHE_HI[p-1]);
        add_wr(10, 1, 0, 1);
        run_periods(3);
        chk("t3_c0_p1", hi[1][1], 0);
        chk("t3_c0_p2", hi[2][1], 0);

        // Write landing in the exact wrap cycle (sample 30 precedes the wrap edge).
        add_wr(30, 2, 7, 0);
        run_periods(2);
        chk("t4_before", hi[0][2], 0);
        chk("t4_wrap_write", hi[1][2], 14);

        // Ceiling lowered while ramping up, then switch to static.
        add_wr(10, 3, 10, 1);
        add_wr(9 * 32 + 10, 3, 4, 1);
        add_wr(11 * 32 + 10, 3, 9, 0);
        run_periods(13);
        chk("t5_level8", hi[9][3], 16);
        chk("t5_clamp4", hi[10][3], 8);
        chk("t5_down3", hi[11][3], 6);
        chk("t5_static9", hi[12][3], 18);

        // EN dropped for 7 cycles mid-period: period stretches, high time kept.
        en_from = 10;
        en_len  = 7;
        run_periods(2);
        chk("t6_len_stretched", plen[0], 39);
        chk("t6_ch0_hi", hi[0][0], 30);
        chk("t6_len_after", plen[1], 32);
        chk("t6_ch0_hi_after", hi[1][0], 30);

        // Asynchronous reset between edges, during a PERIOD_END pulse.
        wait_pe();
        #2 rst = 1'b1;
        #1;
        chk("t7_async_pe", int'(pe), 0);
        chk("t7_async_led_a", int'(led), 0);
        @(negedge clk);
        rst = 1'b0;
        add_wr(2, 0, 15, 0);
        run_periods(2);
        repeat (3) @(negedge clk);
        chk("t7_pre_led0", int'(led[0]), 1);
        wr_en = 1'b1; wr_addr = 3'd0; wr_duty = 4'd8; wr_mode = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t7_async_led_b", int'(led), 0);
        chk("t7_async_pe_b", int'(pe), 0);
        @(negedge clk);
        rst = 1'b0;
        run_periods(2);
        chk("t7_cleared_p0", hi[0][0], 0);
        chk("t7_shadow_cleared", hi[1][0], 0);

        // Randomised traffic checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 15) != 0);
            wr_en   = ($urandom_range(0, 63) == 0);
            wr_addr = AW'($urandom_range(0, 7));
            wr_duty = CNT_W'($urandom_range(0, 15));
            wr_mode = ($urandom_range(0, 2) != 0);
            if (k == 1500) rst = 1'b1;
            if (k == 1502) rst = 1'b0;
        end
        @(negedge clk);
        wr_en = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
